// File: rtl/calc_scheduler_pkg.sv
// Shared definitions for the two-requester line-job scheduler.
package calc_scheduler_pkg;

   localparam int NUM_REQ     = 2;
   localparam int DEF_LINES   = 64;
   localparam int DEF_IDX_W   = 6;
   localparam int DEF_TIMEOUT = 255;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_REG   = 3'd2,
      S_CAL   = 3'd3,
      S_WAIT  = 3'd4,
      S_WRITE = 3'd5,
      S_FIN   = 3'd6
   } state_t;

endpackage

// File: rtl/calc_scheduler_rr_arbiter_2.sv
// Two-way round-robin arbiter; remembers which requester finished last.
module rr_arbiter_2
   import calc_scheduler_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               update,
   input  logic               owner,
   output logic [NUM_REQ-1:0] grant
);

   // 1 means requester 1 was served last, so requester 0 wins a tie
   logic last;

   // Record the owner of each finished job; reset favours requester 0
   always_ff @(posedge clk) begin
      if (!rst) begin
         last <= 1'b1;
      end else if (update) begin
         last <= owner;
      end
   end

   // Single request wins outright; a tie goes to the one not served last
   always_comb begin
      grant = '0;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last ? 2'b01 : 2'b10;
         default: grant = '0;
      endcase
   end

endmodule

// File: rtl/calc_scheduler.sv
// Job scheduler sharing one line datapath between two requesters.
// Each job loads an input set, then walks LINES lines through
// register load, calc handshake (with watchdog) and output write.
module calc_scheduler
   import calc_scheduler_pkg::*;
#(
   parameter int LINES   = DEF_LINES,
   parameter int IDX_W   = DEF_IDX_W,
   parameter int TIMEOUT = DEF_TIMEOUT
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               cal_done,
   input  logic               out_ready,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   line_index,
   output logic               read_file,
   output logic               write_reg,
   output logic               cal_start,
   output logic               write_file,
   output logic [NUM_REQ-1:0] done,
   output logic               err,
   output logic               busy
);

   localparam int                WD_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LINES - 1);
   localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT);

   state_t             state, state_nx;
   logic [NUM_REQ-1:0] gnt_nx;
   logic [IDX_W-1:0]   idx_nx;
   logic [WD_W-1:0]    wdog, wdog_nx;
   logic               abort, abort_nx;
   logic [NUM_REQ-1:0] arb_grant;

   rr_arbiter_2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .update (state == S_FIN),
      .owner  (gnt[1]),
      .grant  (arb_grant)
   );

   // State, owner, line counter, watchdog and abort flag registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= S_IDLE;
         gnt        <= '0;
         line_index <= '0;
         wdog       <= '0;
         abort      <= 1'b0;
      end else begin
         state      <= state_nx;
         gnt        <= gnt_nx;
         line_index <= idx_nx;
         wdog       <= wdog_nx;
         abort      <= abort_nx;
      end
   end

   // Next-state logic; req is only looked at in IDLE, cal_done only in WAIT
   always_comb begin
      state_nx = state;
      gnt_nx   = gnt;
      idx_nx   = line_index;
      wdog_nx  = wdog;
      abort_nx = abort;
      case (state)
         S_IDLE: begin
            if (req != '0) begin
               gnt_nx   = arb_grant;
               abort_nx = 1'b0;
               state_nx = S_LOAD;
            end
         end
         S_LOAD: begin
            idx_nx   = '0;
            state_nx = S_REG;
         end
         S_REG: begin
            state_nx = S_CAL;
         end
         S_CAL: begin
            wdog_nx  = '0;
            state_nx = S_WAIT;
         end
         S_WAIT: begin
            if (cal_done) begin
               state_nx = S_WRITE;
            end else begin
               wdog_nx = wdog + WD_W'(1);
               // Abort once the wait reaches TIMEOUT cycles
               if ((TIMEOUT != 0) && (wdog_nx == WD_LIMIT)) begin
                  abort_nx = 1'b1;
                  state_nx = S_FIN;
               end
            end
         end
         S_WRITE: begin
            if (out_ready) begin
               if (line_index == LAST_IDX) begin
                  state_nx = S_FIN;
               end else begin
                  idx_nx   = line_index + IDX_W'(1);
                  state_nx = S_REG;
               end
            end
         end
         S_FIN: begin
            gnt_nx   = '0;
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Strobes decoded from state; write_file is also qualified by out_ready
   always_comb begin
      read_file  = (state == S_LOAD);
      write_reg  = (state == S_REG);
      cal_start  = (state == S_CAL);
      write_file = (state == S_WRITE) && out_ready;
      done       = (state == S_FIN) ? gnt : '0;
      err        = (state == S_FIN) && abort;
      busy       = (state != S_IDLE);
   end

endmodule
